tryx_axi_arbiter: RTL



---
 rtl/tryx_axi_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tryx_axi_arbiter.sv
// Round-robin arbiter sharing one external periph/AXI port among NB_CORES TRYX-tagged
// request channels, with an in-order ID FIFO steering responses back to the issuing core.
module tryx_axi_arbiter #(
    parameter int unsigned NB_CORES        = 8,
    parameter int unsigned AXI_USER_WIDTH  = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic [NB_CORES-1:0]                core_req_i,
    input  logic [NB_CORES*32-1:0]             core_add_i,
    input  logic [NB_CORES-1:0]                core_wen_i,
    input  logic [NB_CORES*32-1:0]             core_wdata_i,
    input  logic [NB_CORES*4-1:0]              core_be_i,
    input  logic [NB_CORES*AXI_USER_WIDTH-1:0] core_user_i,
    output logic [NB_CORES-1:0]                core_gnt_o,
    output logic [NB_CORES-1:0]                core_r_valid_o,
    output logic [31:0]                        core_r_rdata_o,
    output logic                               core_r_opc_o,
    output logic [NB_CORES-1:0]                axi_xresp_valid_o,
    output logic [NB_CORES-1:0]                axi_xresp_decerr_o,
    output logic [NB_CORES-1:0]                axi_xresp_slverr_o,

    output logic                               mst_req_o,
    output logic [31:0]                        mst_add_o,
    output logic                               mst_wen_o,
    output logic [31:0]                        mst_wdata_o,
    output logic [3:0]                         mst_be_o,
    output logic [AXI_USER_WIDTH-1:0]          mst_user_o,
    input  logic                               mst_gnt_i,
    input  logic                               mst_r_valid_i,
    input  logic [31:0]                        mst_r_rdata_i,
    input  logic                               mst_r_opc_i,
    input  logic                               mst_resp_decerr_i,
    input  logic                               mst_resp_slverr_i,

    output logic                               spurious_o
);

    localparam int unsigned IDX_W = $clog2(NB_CORES);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]               add_a   [NB_CORES];
    logic [31:0]               wdata_a [NB_CORES];
    logic [3:0]                be_a    [NB_CORES];
    logic [AXI_USER_WIDTH-1:0] user_a  [NB_CORES];

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_id_q, lock_id_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spurious_q, spurious_d;

    logic [IDX_W-1:0] winner;
    logic             have_winner;
    int unsigned      cand;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;

    for (genvar g = 0; g < NB_CORES; g++) begin : g_unpack
        assign add_a[g]   = core_add_i[g*32 +: 32];
        assign wdata_a[g] = core_wdata_i[g*32 +: 32];
        assign be_a[g]    = core_be_i[g*4 +: 4];
        assign user_a[g]  = core_user_i[g*AXI_USER_WIDTH +: AXI_USER_WIDTH];
    end

    // Winner: a stalled (locked) request keeps priority, otherwise round-robin from rr_ptr_q
    always_comb begin
        winner      = '0;
        have_winner = 1'b0;
        cand        = 0;
        if (lock_q && core_req_i[lock_id_q]) begin
            winner      = lock_id_q;
            have_winner = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NB_CORES; i++) begin
                cand = (32'(rr_ptr_q) + i) % NB_CORES;
                if (!have_winner && core_req_i[IDX_W'(cand)]) begin
                    winner      = IDX_W'(cand);
                    have_winner = 1'b1;
                end
            end
        end
    end

    assign mst_req_o = (|core_req_i) && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign handshake = mst_req_o && mst_gnt_i;
    assign pop       = mst_r_valid_i && (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    // Request mux toward the external port and grant steering
    always_comb begin
        mst_add_o   = '0;
        mst_wen_o   = 1'b1;
        mst_wdata_o = '0;
        mst_be_o    = '0;
        mst_user_o  = '0;
        core_gnt_o  = '0;
        if (have_winner) begin
            mst_add_o   = add_a[winner];
            mst_wen_o   = core_wen_i[winner];
            mst_wdata_o = wdata_a[winner];
            mst_be_o    = be_a[winner];
            mst_user_o  = user_a[winner];
        end
        if (handshake) begin
            core_gnt_o[winner] = 1'b1;
        end
    end

    // Response steering to the core at the FIFO head
    always_comb begin
        core_r_valid_o     = '0;
        axi_xresp_valid_o  = '0;
        axi_xresp_decerr_o = '0;
        axi_xresp_slverr_o = '0;
        if (pop) begin
            core_r_valid_o[head]     = 1'b1;
            axi_xresp_valid_o[head]  = 1'b1;
            axi_xresp_decerr_o[head] = mst_resp_decerr_i;
            axi_xresp_slverr_o[head] = mst_resp_slverr_i;
        end
    end

    assign core_r_rdata_o = mst_r_rdata_i;
    assign core_r_opc_o   = mst_r_opc_i;
    assign spurious_o     = spurious_q;

    // Next-state for arbitration pointer, lock and FIFO bookkeeping
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        spurious_d = spurious_q;

        if (handshake) begin
            rr_ptr_d = (winner == IDX_W'(NB_CORES - 1)) ? '0 : winner + IDX_W'(1);
            lock_d   = 1'b0;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else if (mst_req_o) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end else if (lock_q && !core_req_i[lock_id_q]) begin
            lock_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({handshake, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (mst_r_valid_i && (count_q == '0)) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
            if (handshake) begin
                fifo_q[wr_ptr_q] <= winner;
            end
        end
    end

endmodule
